// File: rtl/hash_op_arbiter_pkg.sv
// Shared definitions for the hash operation arbiter: op encodings, FSM states
// and default bus widths.
package hash_op_arbiter_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_VALUE_SIZE = 32;
  localparam int unsigned DEF_DATA_SIZE  = 512;
  localparam int unsigned DEF_TIMEOUT    = 255;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    SAMPLE   = 3'd2,
    WAIT_SSD = 3'd3,
    RESP     = 3'd4
  } state_e;

  // Inserts and deletes touch the SSD and must wait for its completion.
  function automatic logic is_mutating(input logic [1:0] op);
    return (op == OP_INSERT) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/hash_op_arbiter_rr_arbiter.sv
// Round-robin grant selection: searches upward from the index after the last
// grant, wrapping to 0, and returns a one-hot grant (zero when nobody requests).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_c
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        grant_c[cand] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_op_arbiter.sv
// Serialises lookup/insert/delete requests from several requesters onto one
// hash table, waiting for SSD completion on successful mutations.
module hash_op_arbiter
  import hash_op_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned VALUE_SIZE = DEF_VALUE_SIZE,
  parameter int unsigned DATA_SIZE  = DEF_DATA_SIZE,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [WIDTH*NUM_REQ-1:0]     req_key,
  input  logic [DATA_SIZE*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic                         resp_hit,
  output logic                         resp_success,
  output logic                         resp_timeout,
  output logic [VALUE_SIZE-1:0]        resp_value,
  output logic [1:0]                   operation,
  output logic [WIDTH-1:0]             key,
  output logic [DATA_SIZE-1:0]         photo_data,
  input  logic [VALUE_SIZE-1:0]        value_out,
  input  logic                         hit,
  input  logic                         success,
  input  logic [VALUE_SIZE-1:0]        ssd_addr_in,
  input  logic                         ssd_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [1:0]            lat_op_q, lat_op_d;
  logic                  cap_hit_q, cap_hit_d;
  logic                  cap_success_q, cap_success_d;
  logic                  cap_timeout_q, cap_timeout_d;
  logic [VALUE_SIZE-1:0] cap_value_q, cap_value_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    ready_d, resp_valid_d;
  logic                  resp_hit_d, resp_success_d, resp_timeout_d;
  logic [VALUE_SIZE-1:0] resp_value_d;
  logic [1:0]            operation_d;
  logic [WIDTH-1:0]      key_d;
  logic [DATA_SIZE-1:0]  photo_data_d;

  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      sel_idx;
  logic [1:0]            sel_op;
  logic [WIDTH-1:0]      sel_key;
  logic [DATA_SIZE-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .grant_c    (grant_c)
  );

  // Index of the requester currently offered req_ready.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_op   = req_op[sel_idx*2 +: 2];
  assign sel_key  = req_key[sel_idx*WIDTH +: WIDTH];
  assign sel_data = req_data[sel_idx*DATA_SIZE +: DATA_SIZE];

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    owner_d        = owner_q;
    lat_op_d       = lat_op_q;
    cap_hit_d      = cap_hit_q;
    cap_success_d  = cap_success_q;
    cap_timeout_d  = cap_timeout_q;
    cap_value_d    = cap_value_q;
    cnt_d          = cnt_q;
    ready_d        = '0;
    resp_valid_d   = '0;
    resp_hit_d     = resp_hit;
    resp_success_d = resp_success;
    resp_timeout_d = resp_timeout;
    resp_value_d   = resp_value;
    operation_d    = OP_NOP;
    key_d          = '0;
    photo_data_d   = '0;

    unique case (state_q)
      IDLE: begin
        // Grant is offered for one cycle; the handshake completes on the next.
        if (|req_ready) begin
          if (|(req_valid & req_ready)) begin
            owner_d      = sel_idx;
            lat_op_d     = sel_op;
            operation_d  = sel_op;
            key_d        = sel_key;
            photo_data_d = sel_data;
            state_d      = ISSUE;
          end
        end else if (|req_valid) begin
          ready_d = grant_c;
        end
      end

      ISSUE: state_d = SAMPLE;

      SAMPLE: begin
        cap_timeout_d = 1'b0;
        if (lat_op_q == OP_NOP) begin
          cap_hit_d     = 1'b0;
          cap_success_d = 1'b0;
          cap_value_d   = '0;
          state_d       = RESP;
        end else begin
          cap_hit_d     = hit;
          cap_success_d = success;
          if (is_mutating(lat_op_q) && success) begin
            cap_value_d = value_out;
            cnt_d       = '0;
            state_d     = WAIT_SSD;
          end else begin
            cap_value_d = (lat_op_q == OP_LOOKUP) ? value_out : '0;
            state_d     = RESP;
          end
        end
      end

      WAIT_SSD: begin
        if (ssd_done) begin
          if (lat_op_q == OP_INSERT) cap_value_d = ssd_addr_in;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            cap_timeout_d = 1'b1;
            cap_success_d = 1'b0;
            cap_value_d   = '0;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        resp_valid_d   = NUM_REQ'(1) << owner_q;
        resp_hit_d     = cap_hit_q;
        resp_success_d = cap_success_q;
        resp_timeout_d = cap_timeout_q;
        resp_value_d   = cap_value_q;
        last_d         = owner_q;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_q        <= IDX_W'(NUM_REQ - 1);
      owner_q       <= '0;
      lat_op_q      <= OP_NOP;
      cap_hit_q     <= 1'b0;
      cap_success_q <= 1'b0;
      cap_timeout_q <= 1'b0;
      cap_value_q   <= '0;
      cnt_q         <= '0;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_hit      <= 1'b0;
      resp_success  <= 1'b0;
      resp_timeout  <= 1'b0;
      resp_value    <= '0;
      operation     <= OP_NOP;
      key           <= '0;
      photo_data    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      lat_op_q      <= lat_op_d;
      cap_hit_q     <= cap_hit_d;
      cap_success_q <= cap_success_d;
      cap_timeout_q <= cap_timeout_d;
      cap_value_q   <= cap_value_d;
      cnt_q         <= cnt_d;
      req_ready     <= ready_d;
      resp_valid    <= resp_valid_d;
      resp_hit      <= resp_hit_d;
      resp_success  <= resp_success_d;
      resp_timeout  <= resp_timeout_d;
      resp_value    <= resp_value_d;
      operation     <= operation_d;
      key           <= key_d;
      photo_data    <= photo_data_d;
    end
  end

endmodule

// File: tb/tb_hash_op_arbiter.sv
// Directed bench for hash_op_arbiter with behavioural hash table and SSD
// models; expected responses are queued at grant and checked at resp_valid.
module tb_hash_op_arbiter;
  import hash_op_arbiter_pkg::*;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned VALUE_SIZE = 32;
  localparam int unsigned DATA_SIZE  = 512;
  localparam int unsigned TIMEOUT    = 20;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic [NUM_REQ-1:0]           req_valid, req_ready, resp_valid;
  logic [2*NUM_REQ-1:0]         req_op;
  logic [WIDTH*NUM_REQ-1:0]     req_key;
  logic [DATA_SIZE*NUM_REQ-1:0] req_data;
  logic                         resp_hit, resp_success, resp_timeout;
  logic [VALUE_SIZE-1:0]        resp_value;
  logic [1:0]                   operation;
  logic [WIDTH-1:0]             key;
  logic [DATA_SIZE-1:0]         photo_data;
  logic [VALUE_SIZE-1:0]        value_out = '0;
  logic                         hit = 1'b0, success = 1'b0;
  logic [VALUE_SIZE-1:0]        ssd_addr_in;
  logic                         ssd_done, ssd_done_m = 1'b0, ssd_stray, ssd_force_low;
  int                           ssd_delay;

  hash_op_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .VALUE_SIZE(VALUE_SIZE),
    .DATA_SIZE(DATA_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_success(resp_success),
    .resp_timeout(resp_timeout), .resp_value(resp_value),
    .operation(operation), .key(key), .photo_data(photo_data),
    .value_out(value_out), .hit(hit), .success(success),
    .ssd_addr_in(ssd_addr_in), .ssd_done(ssd_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign ssd_done = ssd_done_m | ssd_stray;

  // Hash table and SSD models: the table answers the cycle after an issued op;
  // the SSD completes ssd_delay wait cycles later and then commits an insert.
  logic [31:0] tbl [logic [31:0]];
  int          ssd_cnt = 0;
  logic        pend_ins = 1'b0;
  logic [31:0] pend_key = '0;

  always @(posedge clk) begin
    ssd_done_m <= 1'b0;
    if (operation != OP_NOP) begin
      case (operation)
        OP_LOOKUP: begin
          hit       <= (tbl.exists(key) != 0);
          success   <= (tbl.exists(key) != 0);
          value_out <= (tbl.exists(key) != 0) ? tbl[key] : '0;
        end
        OP_INSERT: begin
          hit       <= (tbl.exists(key) != 0);
          success   <= 1'b1;
          value_out <= '0;
          pend_ins  <= 1'b1;
          pend_key  <= key;
          ssd_cnt   <= ssd_delay;
        end
        default: begin
          if (tbl.exists(key) != 0) begin
            hit       <= 1'b1;
            success   <= 1'b1;
            value_out <= tbl[key];
            tbl.delete(key);
            pend_ins  <= 1'b0;
            ssd_cnt   <= ssd_delay;
          end else begin
            hit       <= 1'b0;
            success   <= 1'b0;
            value_out <= '0;
          end
        end
      endcase
    end else if (ssd_cnt > 0) begin
      ssd_cnt <= ssd_cnt - 1;
      if (ssd_cnt == 1 && !ssd_force_low) begin
        ssd_done_m <= 1'b1;
        if (pend_ins) tbl[pend_key] = ssd_addr_in;
        pend_ins <= 1'b0;
      end
    end
  end

  typedef struct {
    int          idx;
    logic        hit;
    logic        succ;
    logic        tmo;
    logic [31:0] value;
    logic        chk_val;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic exp_t mk(input int idx, input logic h, input logic s, input logic t,
                              input logic [31:0] v, input logic cv, input int lat);
    exp_t e;
    e.idx = idx; e.hit = h; e.succ = s; e.tmo = t; e.value = v; e.chk_val = cv; e.lat = lat;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_ready"},   64'(req_ready),    64'd0);
    check({p, "_rvalid"},  64'(resp_valid),   64'd0);
    check({p, "_op"},      64'(operation),    64'd3);
    check({p, "_key"},     64'(key),          64'd0);
    check({p, "_data"},    64'(|photo_data),  64'd0);
    check({p, "_value"},   64'(resp_value),   64'd0);
    check({p, "_hit"},     64'(resp_hit),     64'd0);
    check({p, "_success"}, 64'(resp_success), 64'd0);
    check({p, "_timeout"}, 64'(resp_timeout), 64'd0);
  endtask

  // Returns once req_ready is seen (checked at the current negedge first).
  task automatic wait_grant(output int g);
    bit ok = 1'b0;
    g = -1;
    for (int i = 0; i < 20; i++) begin
      if (|req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("grant_wait", 64'(ok), 64'd1);
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
  endtask

  task automatic wait_resp(input int unsigned gcyc);
    bit   ok = 1'b0;
    exp_t e;
    for (int i = 0; i < int'(TIMEOUT) + 40; i++) begin
      @(negedge clk);
      if (|resp_valid) begin ok = 1'b1; break; end
    end
    check("resp_wait", 64'(ok), 64'd1);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_owner",   64'(resp_valid),   64'(2'b01 << e.idx));
      check("resp_hit",     64'(resp_hit),     64'(e.hit));
      check("resp_success", 64'(resp_success), 64'(e.succ));
      check("resp_timeout", 64'(resp_timeout), 64'(e.tmo));
      if (e.chk_val) check("resp_value", 64'(resp_value), 64'(e.value));
      check("resp_latency", 64'(cyc - gcyc), 64'(e.lat));
      @(negedge clk);
      check("resp_pulse", 64'(resp_valid), 64'd0);
      if (e.chk_val) check("resp_hold", 64'(resp_value), 64'(e.value));
    end
  endtask

  task automatic run_op(input int r, input logic [1:0] op, input logic [31:0] k,
                        input logic [511:0] d, input exp_t e);
    int          g;
    int unsigned gcyc;
    @(negedge clk);
    req_valid[r]                   = 1'b1;
    req_op[2*r +: 2]               = op;
    req_key[WIDTH*r +: WIDTH]      = k;
    req_data[DATA_SIZE*r +: DATA_SIZE] = d;
    wait_grant(g);
    check("grant_idx", 64'(g), 64'(r));
    gcyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid[r] = 1'b0;
    check("issue_op",    64'(operation), 64'(op));
    check("issue_ready", 64'(req_ready), 64'd0);
    if (op != OP_NOP) begin
      check("issue_key",  64'(key), 64'(k));
      check("issue_data", photo_data[63:0], d[63:0]);
    end
    wait_resp(gcyc);
  endtask

  initial begin
    int          g;
    int unsigned gcyc;
    int          rv;
    reset_n = 1'b0; req_valid = '0; req_op = '0; req_key = '0; req_data = '0;
    ssd_addr_in = '0; ssd_delay = 1; ssd_force_low = 1'b0; ssd_stray = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Miss on empty table, with a stray ssd_done held high throughout.
    ssd_stray = 1'b1;
    run_op(0, OP_LOOKUP, 32'h11, 512'h0, mk(0, 0, 0, 0, 32'h0, 1, 4));
    ssd_stray = 1'b0;

    ssd_delay = 3; ssd_addr_in = 32'h0000_A000;
    run_op(0, OP_INSERT, 32'h5, 512'h50, mk(0, 0, 1, 0, 32'h0000_A000, 1, 7));
    run_op(1, OP_LOOKUP, 32'h5, 512'h0, mk(1, 1, 1, 0, 32'h0000_A000, 1, 4));
    run_op(1, OP_NOP,    32'h5, 512'h0, mk(1, 0, 0, 0, 32'h0, 0, 4));

    ssd_force_low = 1'b1;
    run_op(0, OP_INSERT, 32'h9, 512'h90, mk(0, 0, 0, 1, 32'h0, 0, 4 + int'(TIMEOUT)));
    ssd_force_low = 1'b0;

    ssd_delay = 2;
    run_op(1, OP_DELETE, 32'h5,  512'h0, mk(1, 1, 1, 0, 32'h0, 0, 6));
    run_op(0, OP_LOOKUP, 32'h5,  512'h0, mk(0, 0, 0, 0, 32'h0, 1, 4));
    run_op(0, OP_DELETE, 32'h77, 512'h0, mk(0, 0, 0, 0, 32'h0, 1, 4));

    ssd_delay = 1; ssd_addr_in = 32'h0000_B000;
    run_op(1, OP_INSERT, 32'h22, 512'h220, mk(1, 0, 1, 0, 32'h0000_B000, 1, 5));

    // Abort an insert stuck in WAIT_SSD with an asynchronous reset.
    ssd_force_low = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[3:2] = OP_INSERT;
    req_key[63:32] = 32'h33; req_data[1023:512] = 512'h330;
    wait_grant(g);
    check("abort_grant", 64'(g), 64'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ssd_force_low = 1'b0;
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (|resp_valid) rv++;
    end
    check("abort_no_resp", 64'(rv), 64'd0);

    // Contention after reset: req0 first, then strict alternation.
    req_op = {OP_LOOKUP, OP_LOOKUP};
    req_key = {32'h101, 32'h100};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      check("cont_grant", 64'(g), 64'(i % 2));
      gcyc = cyc;
      sb.push_back(mk(i % 2, 0, 0, 0, 32'h0, 1, 4));
      wait_resp(gcyc);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hash_op_arbiter.md
HASH_OP_ARBITER -- requirements
Module: hash_op_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters; WIDTH, default 32, key width; VALUE_SIZE, default 32, SSD address width; DATA_SIZE, default 512, photo payload width; TIMEOUT, default 255, maximum cycles to wait for ssd_done.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_op  in  2*NUM_REQ  packed op per requester: 00 lookup, 01 insert, 10 delete.
- req_key  in  WIDTH*NUM_REQ  packed keys.
- req_data  in  DATA_SIZE*NUM_REQ  packed photo payloads.
- resp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- resp_hit, resp_success, resp_timeout  out  1 each  response flags, shared.
- resp_value  out  VALUE_SIZE  response SSD address, shared.
- operation  out  2  to hash_table.
- key  out  WIDTH  to hash_table.
- photo_data  out  DATA_SIZE  to hash_table.
- value_out, hit, success  in  VALUE_SIZE/1/1  from hash_table.
- ssd_addr_in  in  VALUE_SIZE  SSD-assigned address.
- ssd_done  in  1  SSD completion.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, SAMPLE, WAIT_SSD and RESP.
REQ-004 IDLE: when any req_valid is set, the FSM SHALL grant round-robin, starting at the index after the last granted one; it SHALL assert req_ready[g] for that cycle only, latch op, key and data, and go to ISSUE.
REQ-005 The handshake SHALL complete when req_valid[g] and req_ready[g] are both high; the requester SHALL hold its fields stable until req_ready.
REQ-006 ISSUE: the FSM SHALL drive operation, key and photo_data from the latch for exactly one cycle, then go to SAMPLE.
REQ-007 operation SHALL be 2'b11 (NOP) in every state other than ISSUE.
REQ-008 SAMPLE: the FSM SHALL capture hit, success and value_out.
- Lookup, or insert/delete with success=0: go to RESP.
- Insert/delete with success=1: go to WAIT_SSD and clear the timeout counter.
REQ-009 WAIT_SSD: on ssd_done, an insert SHALL capture ssd_addr_in into resp_value, and the FSM SHALL go to RESP. The counter SHALL increment each cycle without ssd_done. On reaching TIMEOUT, the FSM SHALL set resp_timeout=1, clear resp_success, and go to RESP.
REQ-010 RESP: resp_valid[g] SHALL pulse for one cycle, with the flags and value held until the next RESP. The round-robin pointer SHALL update to g, and the FSM SHALL return to IDLE.
REQ-011 Exactly one operation SHALL be outstanding; req_ready SHALL be 0 in every state except IDLE.
REQ-012 Latency without SSD wait SHALL be 4 cycles from grant to resp_valid. With SSD wait it SHALL be 4 + N cycles, where N is the number of ssd_done wait cycles.
REQ-013 Pointer wrap: after granting index NUM_REQ-1, the search SHALL start at 0.
REQ-014 If only one requester is valid, it SHALL be granted regardless of the pointer.
REQ-015 An op code of 2'b11 from a requester SHALL be accepted and answered in RESP with resp_success=0 and resp_hit=0, without issuing to the hash table.
REQ-016 An ssd_done that arrives in any state other than WAIT_SSD SHALL be ignored.
REQ-017 lookup resp_value SHALL equal value_out. A failed insert/delete SHALL report resp_value=0.

Reset
REQ-018 Assertion of reset_n low SHALL asynchronously force the following, including mid-operation, with no response issued for an aborted op:
- FSM to IDLE.
- Round-robin pointer to NUM_REQ-1, so requester 0 wins first.
- req_ready=0, resp_valid=0, operation=2'b11.
- key, photo_data, resp_value and the counter to 0.
- resp_hit, resp_success and resp_timeout to 0.
REQ-019 Deassertion SHALL take effect at the next rising clk edge.

Structure
REQ-020 A shared package SHALL hold:
- Op encodings OP_LOOKUP=2'b00, OP_INSERT=2'b01, OP_DELETE=2'b10, OP_NOP=2'b11.
- The FSM state enumeration.
- Default WIDTH, VALUE_SIZE and DATA_SIZE.
REQ-021 The round-robin grant logic SHALL be a sub-module rr_arbiter, parameterised on NUM_REQ, with inputs request vector and last grant and output a one-hot grant.

Verification
REQ-022 The bench SHALL pair the block with hash_table and ssd_sim, and SHALL cover these scenarios:
- Insert: req0 inserts key 0x5, data 0x50 -> resp_valid[0], resp_success=1, resp_value = SSD address; a later lookup of 0x5 returns hit=1 with the same address.
- Contention: req0 and req1 both valid in IDLE after reset -> req0 granted first, req1 next. With both held valid, grants alternate 0,1,0,1.
- Miss: lookup of key 0x11 on an empty table -> resp_hit=0 and resp_value=0 four cycles after grant.
- Timeout: insert with ssd_done forced low -> after TIMEOUT cycles, resp_timeout=1, resp_success=0, and the FSM returns to IDLE.
- Reset abort: reset_n asserted during WAIT_SSD -> outputs at reset values, no resp_valid, and the next request granted to req0.
- Delete: delete of key 0x5 -> success=1, then a lookup of 0x5 gives resp_hit=0. A delete of an absent key -> resp_success=0 with no WAIT_SSD.
